// File: rtl/dpwm_mph.sv
// Multi-phase digital PWM with dead-time insertion.
// A free-running master counter defines the period. NPH phases are interleaved
// by equal offsets. A staged configuration becomes active only at a period
// boundary, so no period ever runs with mixed settings.
module dpwm_mph #(
    parameter int CW     = 11,
    parameter int DW     = 5,
    parameter int NPH    = 2,
    parameter int DEF_TS = 1000
) (
    input  logic              i_clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [CW-1:0]     i_ts,
    input  logic [CW-1:0]     i_ton,
    input  logic [DW-1:0]     i_dt1,
    input  logic [DW-1:0]     i_dt2,
    input  logic              i_upd,
    output logic              o_upd_ack,
    output logic              o_ts_last,
    output logic [NPH-1:0]    c1,
    output logic [NPH-1:0]    c2
);

    // Phase-offset shift amount: log2 of the legal phase counts 1, 2, 4.
    localparam int LG = (NPH >= 4) ? 2 : ((NPH >= 2) ? 1 : 0);
    localparam logic [CW-1:0] DEF_TS_C = CW'(DEF_TS);
    localparam logic [CW-1:0] TS_MIN   = CW'(32'd4);
    localparam logic [CW-1:0] ONE_C    = CW'(32'd1);

    // Offset of phase k: k equal slices of the period.
    function automatic logic [CW-1:0] phase_off(input logic [CW-1:0] ts, input int k);
        logic [CW-1:0] step;
        logic [CW-1:0] kk;
        step = ts >> LG;
        kk   = CW'(k);
        return kk * step;
    endfunction

    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  ts_a_r;
    logic [DW-1:0]  dt1_a_r;
    logic [CW:0]    e1_a_r;      // dt1 + ton: first count with c1 low again
    logic [CW:0]    e2_a_r;      // dt1 + ton + dt2: first count with c2 high
    logic [CW-1:0]  off_a_r [NPH];
    logic [CW-1:0]  stg_ts_r;
    logic [CW-1:0]  stg_ton_r;
    logic [DW-1:0]  stg_dt1_r;
    logic [DW-1:0]  stg_dt2_r;
    logic           pend_r;
    logic           ack_r;
    logic [NPH-1:0] c1_r;
    logic [NPH-1:0] c2_r;

    logic           ts_last_s;
    logic           load_s;
    logic [CW-1:0]  src_ts_s;
    logic [CW-1:0]  src_ton_s;
    logic [DW-1:0]  src_dt1_s;
    logic [DW-1:0]  src_dt2_s;
    logic [CW-1:0]  ts_cl_s;
    logic [CW:0]    dts_s;
    logic [CW:0]    room_s;
    logic [CW:0]    ton_cl_s;
    logic [CW:0]    e1_s;
    logic [CW:0]    e2_s;
    logic [CW:0]    p_s [NPH];
    logic [NPH-1:0] c1_raw_s;
    logic [NPH-1:0] c2_raw_s;

    // Boundary detect and load-time config shaping; a strobe on the boundary
    // cycle bypasses staging so its values win.
    always_comb begin
        ts_last_s = (cnt_r == (ts_a_r - ONE_C));
        load_s    = ts_last_s & (pend_r | i_upd);
        src_ts_s  = i_upd ? i_ts  : stg_ts_r;
        src_ton_s = i_upd ? i_ton : stg_ton_r;
        src_dt1_s = i_upd ? i_dt1 : stg_dt1_r;
        src_dt2_s = i_upd ? i_dt2 : stg_dt2_r;
        ts_cl_s   = (src_ts_s < TS_MIN) ? TS_MIN : src_ts_s;
        dts_s     = (CW+1)'(src_dt1_s) + (CW+1)'(src_dt2_s);
        room_s    = (dts_s >= {1'b0, ts_cl_s}) ? '0 : ({1'b0, ts_cl_s} - dts_s);
        ton_cl_s  = ({1'b0, src_ton_s} < room_s) ? {1'b0, src_ton_s} : room_s;
        e1_s      = (CW+1)'(src_dt1_s) + ton_cl_s;
        e2_s      = e1_s + (CW+1)'(src_dt2_s);
    end

    // Per-phase position in the period and raw gate decisions; the
    // wrap uses one spare bit since cnt and offset are both below ts_a.
    always_comb begin
        c1_raw_s = '0;
        c2_raw_s = '0;
        for (int k = 0; k < NPH; k++) begin
            p_s[k] = {1'b0, cnt_r} + {1'b0, off_a_r[k]};
            p_s[k] = (p_s[k] >= {1'b0, ts_a_r}) ? (p_s[k] - {1'b0, ts_a_r}) : p_s[k];
            c1_raw_s[k] = (p_s[k] >= (CW+1)'(dt1_a_r)) && (p_s[k] < e1_a_r);
            c2_raw_s[k] = (p_s[k] >= e2_a_r);
        end
    end

    // Master period counter, free-running regardless of enable.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= ts_last_s ? '0 : (cnt_r + ONE_C);
        end
    end

    // Staging registers and pending flag; last strobe before a boundary wins.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            stg_ts_r  <= '0;
            stg_ton_r <= '0;
            stg_dt1_r <= '0;
            stg_dt2_r <= '0;
            pend_r    <= 1'b0;
        end else begin
            if (i_upd) begin
                stg_ts_r  <= i_ts;
                stg_ton_r <= i_ton;
                stg_dt1_r <= i_dt1;
                stg_dt2_r <= i_dt2;
            end
            if (load_s) begin
                pend_r <= 1'b0;
            end else if (i_upd) begin
                pend_r <= 1'b1;
            end
        end
    end

    // Active configuration, changed only on the period boundary.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            ts_a_r  <= DEF_TS_C;
            dt1_a_r <= '0;
            e1_a_r  <= '0;
            e2_a_r  <= '0;
            ack_r   <= 1'b0;
            for (int k = 0; k < NPH; k++) begin
                off_a_r[k] <= phase_off(DEF_TS_C, k);
            end
        end else begin
            ack_r <= load_s;
            if (load_s) begin
                ts_a_r  <= ts_cl_s;
                dt1_a_r <= src_dt1_s;
                e1_a_r  <= e1_s;
                e2_a_r  <= e2_s;
                for (int k = 0; k < NPH; k++) begin
                    off_a_r[k] <= phase_off(ts_cl_s, k);
                end
            end
        end
    end

    // Registered gate drives, forced low while disabled.
    always_ff @(posedge i_clk) begin
        if (!reset_n) begin
            c1_r <= '0;
            c2_r <= '0;
        end else begin
            c1_r <= c1_raw_s & {NPH{enable}};
            c2_r <= c2_raw_s & {NPH{enable}};
        end
    end

    assign o_ts_last = ts_last_s;
    assign o_upd_ack = ack_r;
    assign c1        = c1_r;
    assign c2        = c2_r;

endmodule

// File: tb/tb_dpwm_mph.sv
// Scoreboard bench for dpwm_mph (default parameters, two phases).
// Stimulus pushes expected gate/boundary samples and ack cycles into queues;
// a negedge monitor pops and compares them against the DUT.
module tb_dpwm_mph;

    logic        i_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [10:0] i_ts;
    logic [10:0] i_ton;
    logic [4:0]  i_dt1;
    logic [4:0]  i_dt2;
    logic        i_upd;
    logic        o_upd_ack;
    logic        o_ts_last;
    logic [1:0]  c1;
    logic [1:0]  c2;

    dpwm_mph dut (
        .i_clk     (i_clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .i_ts      (i_ts),
        .i_ton     (i_ton),
        .i_dt1     (i_dt1),
        .i_dt2     (i_dt2),
        .i_upd     (i_upd),
        .o_upd_ack (o_upd_ack),
        .o_ts_last (o_ts_last),
        .c1        (c1),
        .c2        (c2)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int         due;
        logic [1:0] c1;
        logic [1:0] c2;
        logic       tl;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic done = 1'b0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic expv(input int due, input logic [1:0] a, input logic [1:0] b,
                        input logic t, input string nm);
        exp_t e;
        e.due = due; e.c1 = a; e.c2 = b; e.tl = t; e.nm = nm;
        exp_q.push_back(e);
    endtask

    task automatic upd(input int ts, input int ton, input int d1, input int d2);
        i_ts  = ts[10:0];
        i_ton = ton[10:0];
        i_dt1 = d1[4:0];
        i_dt2 = d2[4:0];
        i_upd = 1'b1;
        tick();
        i_upd = 1'b0;
    endtask

    // Monitor: compare due samples and every ack pulse; final drain check.
    always @(negedge i_clk) begin
        for (int i = 0; i < exp_q.size(); ) begin
            if (exp_q[i].due <= cyc) begin
                n_cmp++;
                if (exp_q[i].due != cyc || c1 !== exp_q[i].c1 || c2 !== exp_q[i].c2
                    || o_ts_last !== exp_q[i].tl) begin
                    n_bad++;
                    $display("FAIL %s: got c1=%b c2=%b ts_last=%b, want c1=%b c2=%b ts_last=%b (cyc %0d due %0d)",
                             exp_q[i].nm, c1, c2, o_ts_last, exp_q[i].c1, exp_q[i].c2,
                             exp_q[i].tl, cyc, exp_q[i].due);
                end
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
        while (ack_q.size() > 0 && ack_q[0] < cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_missed: got no ack, want ack at cyc %0d", ack_q[0]);
            void'(ack_q.pop_front());
        end
        if (o_upd_ack === 1'b1) begin
            n_cmp++;
            if (ack_q.size() == 0) begin
                n_bad++;
                $display("FAIL ack_unexpected: got ack at cyc %0d, want none", cyc);
            end else begin
                if (ack_q[0] != cyc) begin
                    n_bad++;
                    $display("FAIL ack_cycle: got ack at cyc %0d, want cyc %0d", cyc, ack_q[0]);
                end
                void'(ack_q.pop_front());
            end
        end
        if (done) begin
            n_cmp++;
            if (exp_q.size() != 0 || ack_q.size() != 0) begin
                n_bad++;
                $display("FAIL drain: got %0d samples and %0d acks outstanding, want 0 and 0",
                         exp_q.size(), ack_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int b, p1, p2, p3, q, r, b2;
        reset_n = 1'b0; enable = 1'b0; i_upd = 1'b0;
        i_ts = '0; i_ton = '0; i_dt1 = '0; i_dt2 = '0;
        repeat (3) tick();
        expv(cyc, 2'b00, 2'b00, 1'b0, "reset_state");
        tick();
        reset_n = 1'b1;
        enable  = 1'b1;
        b  = cyc;
        p1 = b + 1000;
        p2 = b + 2000;
        p3 = b + 3000;
        q  = p3 + 200;
        r  = p3 + 300;

        // Default config (ton=0, dt=0): c2 on everywhere, DEF_TS period.
        expv(b + 500, 2'b00, 2'b11, 1'b0, "def_c2");
        expv(b + 998, 2'b00, 2'b11, 1'b0, "def_pre_last");
        expv(b + 999, 2'b00, 2'b11, 1'b1, "def_ts_last");
        // ts=1000 ton=400 dt=5/5 from period 1.
        ack_q.push_back(p1);
        expv(p1,       2'b00, 2'b11, 1'b0, "p1_cnt0");
        expv(p1 + 5,   2'b00, 2'b10, 1'b0, "p1_before_c1");
        expv(p1 + 6,   2'b01, 2'b10, 1'b0, "p1_c1_rise");
        expv(p1 + 350, 2'b01, 2'b10, 1'b0, "p1_no_midchange");
        expv(p1 + 405, 2'b01, 2'b10, 1'b0, "p1_c1_last");
        expv(p1 + 406, 2'b00, 2'b10, 1'b0, "p1_dead2");
        expv(p1 + 411, 2'b00, 2'b11, 1'b0, "p1_c2_rise");
        expv(p1 + 506, 2'b10, 2'b01, 1'b0, "p1_ph1_c1");
        expv(p1 + 650, 2'b10, 2'b01, 1'b0, "p1_late");
        wait_until(b + 10);
        upd(1000, 400, 5, 5);

        // Two strobes in period 1, last wins, single ack at period 2.
        ack_q.push_back(p2);
        expv(p2 + 205, 2'b01, 2'b10, 1'b0, "p2_c1_last");
        expv(p2 + 206, 2'b00, 2'b10, 1'b0, "p2_dead2");
        expv(p2 + 250, 2'b00, 2'b11, 1'b0, "p2_ton200");
        expv(p2 + 999, 2'b00, 2'b11, 1'b1, "p2_ts_last");
        wait_until(p1 + 300);
        upd(1000, 300, 5, 5);
        wait_until(p1 + 600);
        upd(1000, 200, 5, 5);

        // Strobe on the boundary cycle: ts=100 ton=100 dt=10/10 -> ton_a=80.
        ack_q.push_back(p3);
        expv(p3,      2'b00, 2'b11, 1'b0, "p3_cnt0_old");
        expv(p3 + 11, 2'b11, 2'b00, 1'b0, "clamp_c1_rise");
        expv(p3 + 50, 2'b01, 2'b00, 1'b0, "clamp_ph1_gap");
        expv(p3 + 61, 2'b11, 2'b00, 1'b0, "clamp_both_c1");
        expv(p3 + 90, 2'b11, 2'b00, 1'b0, "clamp_c1_last");
        expv(p3 + 91, 2'b10, 2'b00, 1'b0, "clamp_c1_fall");
        expv(p3 + 98, 2'b10, 2'b00, 1'b0, "clamp_pre_last");
        expv(p3 + 99, 2'b10, 2'b00, 1'b1, "clamp_ts_last");
        expv(p3 + 100, 2'b10, 2'b00, 1'b0, "clamp_wrap");
        wait_until(p3 - 1);
        upd(100, 100, 10, 10);

        // Enable dropped for 50 clocks; counter keeps running.
        ack_q.push_back(r);
        expv(q + 20, 2'b11, 2'b00, 1'b0, "en_before");
        expv(q + 21, 2'b00, 2'b00, 1'b0, "en_off_first");
        expv(q + 45, 2'b00, 2'b00, 1'b0, "en_off_mid");
        expv(q + 70, 2'b00, 2'b00, 1'b0, "en_off_last");
        expv(q + 71, 2'b11, 2'b00, 1'b0, "en_resume");
        expv(q + 99, 2'b10, 2'b00, 1'b1, "en_ts_last");
        expv(r,      2'b10, 2'b00, 1'b0, "r_cnt0_old");
        expv(r + 6,  2'b01, 2'b10, 1'b0, "r_c1_rise");
        wait_until(q + 20);
        enable = 1'b0;
        wait_until(q + 50);
        upd(1000, 400, 5, 5);
        wait_until(q + 70);
        enable = 1'b1;

        // Reset at cnt=700 with ts=200 pending: discarded, no ack.
        expv(r + 701, 2'b00, 2'b00, 1'b0, "rst_mid_out");
        expv(r + 703, 2'b00, 2'b00, 1'b0, "rst_mid_hold");
        wait_until(r + 300);
        upd(200, 50, 2, 2);
        wait_until(r + 700);
        reset_n = 1'b0;
        wait_until(r + 703);
        reset_n = 1'b1;
        b2 = cyc;
        expv(b2,       2'b00, 2'b00, 1'b0, "rel_cnt0");
        expv(b2 + 5,   2'b00, 2'b11, 1'b0, "rel_default");
        expv(b2 + 199, 2'b00, 2'b11, 1'b0, "rel_no_ts200");
        expv(b2 + 999, 2'b00, 2'b11, 1'b1, "rel_def_ts");
        wait_until(b2 + 1010);
        done = 1'b1;
    end

endmodule
